// File: rtl/spi_ram_ctrl_if.sv
// rtl/spi_ram_ctrl_if.sv - SPI slave to RAM controller word/byte handshake
interface spi_ram_ctrl_if;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;

  modport master (output din, rx_valid, input  dout, tx_valid);
  modport slave  (input  din, rx_valid, output dout, tx_valid);
endinterface

// File: rtl/spi_ram_ctrl.sv
// rtl/spi_ram_ctrl.sv - command-decoded single-port RAM behind an SPI slave
// Commands fire once per rx_valid rising edge; read data is held valid for TX_HOLD cycles.
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter bit AUTO_INC  = 1'b0,
  parameter int TX_HOLD   = 9
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_ram_ctrl_if.slave  bus
);

  localparam int                   CW        = $clog2(TX_HOLD);
  localparam logic [CW-1:0]        HOLD_LOAD = CW'(TX_HOLD - 1);
  localparam logic [ADDR_SIZE-1:0] LAST      = ADDR_SIZE'(MEM_DEPTH - 1);
  localparam logic [ADDR_SIZE:0]   DEPTH     = (ADDR_SIZE + 1)'(MEM_DEPTH);

  logic [7:0]           mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic [CW-1:0]        hold_cnt;
  logic                 rx_valid_d;
  logic                 accept;
  logic [1:0]           cmd;
  logic [7:0]           payload;

  assign accept  = bus.rx_valid & ~rx_valid_d;
  assign cmd     = bus.din[9:8];
  assign payload = bus.din[7:0];

  function automatic logic in_range(input logic [ADDR_SIZE-1:0] a);
    return {1'b0, a} < DEPTH;
  endfunction

  // Out-of-range addresses keep counting and roll over at the address width.
  function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
    return (a == LAST) ? '0 : a + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst_n && accept && cmd == 2'b01 && in_range(wr_addr))
      mem[wr_addr] <= payload;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.dout     <= 8'h00;
      bus.tx_valid <= 1'b0;
      wr_addr      <= '0;
      rd_addr      <= '0;
      hold_cnt     <= '0;
      rx_valid_d   <= 1'b0;
    end else begin
      rx_valid_d <= bus.rx_valid;
      if (hold_cnt != '0)
        hold_cnt <= hold_cnt - 1'b1;
      else if (bus.tx_valid)
        bus.tx_valid <= 1'b0;

      if (accept) begin
        case (cmd)
          2'b00: wr_addr <= payload[ADDR_SIZE-1:0];
          2'b01: if (AUTO_INC) wr_addr <= next_addr(wr_addr);
          2'b10: rd_addr <= payload[ADDR_SIZE-1:0];
          default: begin
            // A read during an active hold restarts the window with no gap.
            bus.dout     <= in_range(rd_addr) ? mem[rd_addr] : 8'h00;
            bus.tx_valid <= 1'b1;
            hold_cnt     <= HOLD_LOAD;
            if (AUTO_INC) rd_addr <= next_addr(rd_addr);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb/tb_spi_ram_ctrl.sv - directed bench for spi_ram_ctrl in three parameterisations
module tb_spi_ram_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] din;
  logic       rx_valid;
  int         checks = 0;
  int         errors = 0;
  int         n;

  always #5 clk = ~clk;

  // u0: defaults, u1: AUTO_INC=1, u2: MEM_DEPTH=200; all see the same stimulus.
  spi_ram_ctrl_if if0 ();
  spi_ram_ctrl_if if1 ();
  spi_ram_ctrl_if if2 ();
  assign if0.din = din; assign if0.rx_valid = rx_valid;
  assign if1.din = din; assign if1.rx_valid = rx_valid;
  assign if2.din = din; assign if2.rx_valid = rx_valid;

  spi_ram_ctrl u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  spi_ram_ctrl #(.AUTO_INC(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  spi_ram_ctrl #(.MEM_DEPTH(200)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  logic [2:0] tx_all;
  assign tx_all = {if2.tx_valid, if1.tx_valid, if0.tx_valid};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [9:0] w);
    din = w;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send(input logic [9:0] w);
    pulse(w);
    tick();
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic run_len(input int k, output int len);
    len = 0;
    while (tx_all[k] === 1'b1 && len < 40) begin
      len++;
      tick();
    end
  endtask

  task automatic settle();
    repeat (12) tick();
  endtask

  initial begin
    rst_n = 1'b0; din = '0; rx_valid = 1'b0;
    tick(); tick();
    chk8("reset_dout", if0.dout, 8'h00);
    chk1("reset_tx", if0.tx_valid, 1'b0);
    chk1("reset_tx_u1", if1.tx_valid, 1'b0);
    rst_n = 1'b1;
    tick();

    // basic write then read, latency 1, 9-cycle hold, dout retained
    send(10'h02A); send(10'h15C); send(10'h22A);
    chk1("no_tx_before_read", if0.tx_valid, 1'b0);
    pulse(10'h300);
    chk8("t1_dout", if0.dout, 8'h5C);
    chk1("t1_tx", if0.tx_valid, 1'b1);
    chk8("t1_dout_u2", if2.dout, 8'h5C);
    run_len(0, n);
    chk8("t1_hold_len", 8'(n), 8'd9);
    chk1("t1_tx_low", if0.tx_valid, 1'b0);
    chk8("t1_dout_kept", if0.dout, 8'h5C);

    // held rx_valid executes once
    send(10'h010);
    din = 10'h177; rx_valid = 1'b1;
    repeat (12) tick();
    rx_valid = 1'b0; tick();
    send(10'h188); send(10'h210);
    pulse(10'h300);
    chk8("t2_u0_rd10", if0.dout, 8'h88);
    chk8("t2_u1_rd10", if1.dout, 8'h77);
    tick();
    pulse(10'h300);
    chk8("t2_u1_rd11", if1.dout, 8'h88);
    settle();

    // auto-increment wrap at top of memory; u2 sees 0xFF as out of range
    send(10'h0FF); send(10'h1A1); send(10'h1A2); send(10'h2FF);
    pulse(10'h300);
    chk8("t3_u1_rdff", if1.dout, 8'hA1);
    chk8("t3_u0_rdff", if0.dout, 8'hA2);
    chk8("t3_u2_oor", if2.dout, 8'h00);
    chk1("t3_u2_tx", if2.tx_valid, 1'b1);
    tick();
    pulse(10'h300);
    chk8("t3_u1_rd00", if1.dout, 8'hA2);
    settle();

    // depth 200: last valid address works, 0xF0 dropped and reads 0
    send(10'h0C7); send(10'h15A); send(10'h2C7);
    pulse(10'h300);
    chk8("t4_u2_rdc7", if2.dout, 8'h5A);
    settle();
    send(10'h0F0); send(10'h133); send(10'h2F0);
    pulse(10'h300);
    chk8("t4_u2_oor", if2.dout, 8'h00);
    chk8("t4_u0_rdf0", if0.dout, 8'h33);
    run_len(2, n);
    chk8("t4_u2_hold_len", 8'(n), 8'd9);

    // read-data re-accepted at hold count 3
    send(10'h050); send(10'h199); send(10'h22A);
    pulse(10'h300);
    chk8("t5_first", if0.dout, 8'h5C);
    tick();
    send(10'h250);
    chk8("t5_rdaddr_keeps_dout", if0.dout, 8'h5C);
    chk1("t5_rdaddr_keeps_tx", if0.tx_valid, 1'b1);
    tick(); tick();
    chk1("t5_tx_before", if0.tx_valid, 1'b1);
    pulse(10'h300);
    chk8("t5_switch", if0.dout, 8'h99);
    run_len(0, n);
    chk8("t5_hold_len", 8'(n), 8'd9);

    // back-to-back write then read of the same address
    send(10'h260); send(10'h060); send(10'h14E);
    pulse(10'h300);
    chk8("t5b_wr_rd", if0.dout, 8'h4E);
    settle();

    // reset during hold
    send(10'h22A);
    pulse(10'h300);
    tick(); tick();
    chk8("t6_pre", if0.dout, 8'h5C);
    rst_n = 1'b0;
    tick();
    chk8("t6_rst_dout", if0.dout, 8'h00);
    chk1("t6_rst_tx", if0.tx_valid, 1'b0);
    rst_n = 1'b1;
    tick();
    chk1("t6_tx_idle", if0.tx_valid, 1'b0);
    send(10'h22A);
    pulse(10'h300);
    chk8("t6_mem_kept", if0.dout, 8'h5C);
    chk1("t6_tx", if0.tx_valid, 1'b1);
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
Single-port synchronous RAM with command decoder, sitting directly downstream of the SPI slave. It consumes the slave's 10-bit received word and its valid strobe, and executes write-address, write-data, read-address and read-data commands. For read-data it returns a byte plus a held valid, which the slave shifts out on MISO.

Parameters:
MEM_DEPTH, 256, number of 8-bit words; must be ≤ 2^ADDR_SIZE.
ADDR_SIZE, 8, address register width; must be ≤ 8 (the payload is 8 bits).
AUTO_INC, 0, if 1, wr_addr and rd_addr post-increment after each data access.
TX_HOLD, 9, number of cycles tx_valid stays high per read; must be ≥ 9.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
din  input  10  command word from SPI slave: [9:8] command, [7:0] payload
rx_valid  input  1  slave's word-valid; level, may stay high for many cycles
dout  output  8  read-data byte to SPI slave
tx_valid  output  1  dout valid for slave shift-out

Behaviour:
- Reset (rst_n low at clk edge):
  - dout=0, tx_valid=0.
  - wr_addr=0, rd_addr=0, hold counter=0, rx_valid history register=0.
  - Memory contents are not cleared.
- Command acceptance: a command is accepted only on a rising edge of rx_valid, i.e. rx_valid=1 now and 0 in the registered previous sample. A level held high executes exactly once.
- Command 00 (write address): wr_addr <= din[ADDR_SIZE-1:0] on the accepting edge.
- Command 01 (write data): mem[wr_addr] <= din[7:0] on the accepting edge.
  - If AUTO_INC, wr_addr <= wr_addr+1, wrapping to 0 after MEM_DEPTH-1.
- Command 10 (read address): rd_addr <= din[ADDR_SIZE-1:0].
- Command 11 (read data): payload is ignored.
  - On the accepting edge, dout <= mem[rd_addr] and tx_valid <= 1, so both are visible in the cycle after acceptance (latency 1).
  - The hold counter loads TX_HOLD-1.
  - If AUTO_INC, rd_addr then increments, wrapping.
- Hold: while the counter is > 0, it decrements each cycle; tx_valid and dout stay stable. When the counter reaches 0 with tx_valid high, tx_valid <= 0 next cycle. tx_valid is high for exactly TX_HOLD cycles.
- dout retains its last read value after tx_valid falls; it is changed only by a new read or by reset.
- Out of range (address ≥ MEM_DEPTH):
  - A write is dropped (no memory change); AUTO_INC still advances and wraps.
  - A read returns dout=0 with a normal tx_valid pulse.
- Simultaneous events:
  - Command 11 accepted while a hold is active: dout reloads, the counter reloads to TX_HOLD-1, tx_valid stays high with no gap.
  - Commands 00/01/10 accepted during a hold execute normally and do not disturb dout, tx_valid or the counter.
  - Write data then read data to the same address in back-to-back accepted commands: the read returns the newly written value. Memory reads are issued only on acceptance edges, which are at least 2 cycles apart, so no bypass is needed.
- Reset mid-hold: tx_valid drops to 0 and dout to 0 on the reset edge; the counter clears. A pending rx_valid rising edge coincident with reset is discarded.
- No state machine beyond the hold counter and edge detector. The design is fully synchronous, single clock, and has no combinational path from inputs to outputs.

Test Plan:
1. Write path: rx_valid pulses with din=0x0_2A (wr addr 0x2A), then 0x1_5C (data), then 0x2_2A (rd addr), then 0x3_00 → cycle after last accept dout=0x5C, tx_valid high exactly 9 cycles, then 0.
2. rx_valid held high 12 cycles with din=0x1_77 after wr addr 0x10 → mem[0x10]=0x77 written once. With AUTO_INC=1, wr_addr ends at 0x11, not 0x1C.
3. AUTO_INC=1, wr addr 0xFF, write 0xA1 then 0xA2 → mem[0xFF]=0xA1, mem[0x00]=0xA2. Reads at rd addr 0xFF twice return 0xA1, then 0xA2.
4. MEM_DEPTH=200: write 0x33 at addr 0xF0, then read at 0xF0 → memory unchanged, dout=0x00, tx_valid pulse of TX_HOLD cycles.
5. Read-data accepted at hold count 3, second read-data at a new rd_addr holding 0x99 → tx_valid continuous, dout switches to 0x99 one cycle after the second accept, tx_valid high for 9 cycles from that point.
6. rst_n low during an active hold with dout=0x5C → next edge dout=0, tx_valid=0. After release, a read of the previously written address still returns 0x5C.
